// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Redirect class codes are ordered so a larger value means higher priority.
package fetch_ctrl_pkg;

    localparam int           PC_STEP        = 4;
    localparam logic [31:0]  PC_START_DEF   = 32'h0000_0000;
    localparam logic [31:0]  EXC_VECTOR_DEF = 32'h0000_0020;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic {
        FC_S_IDLE  = 1'b0,
        FC_S_FETCH = 1'b1
    } fc_state_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_ERET = 2'd2,
        RD_EXC  = 2'd3
    } redir_cls_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: ROM handshake, redirect requests and IF/ID controls.
// master is the sequencer side, slave is the pipeline/ROM side.
interface fetch_ctrl_if #(
    parameter int PC_W = 32
);
    logic            rom_ready;
    logic            stall_req;
    logic            br_req;
    logic [PC_W-1:0] br_addr;
    logic            exc_req;
    logic [PC_W-1:0] exc_pc;
    logic            eret_req;
    logic [PC_W-1:0] pc;
    logic            romCe;
    logic            if_valid;
    logic            flush;
    logic [PC_W-1:0] epc;

    modport master (
        input  rom_ready, stall_req, br_req, br_addr,
        input  exc_req, exc_pc, eret_req,
        output pc, romCe, if_valid, flush, epc
    );

    modport slave (
        output rom_ready, stall_req, br_req, br_addr,
        output exc_req, exc_pc, eret_req,
        input  pc, romCe, if_valid, flush, epc
    );
endinterface

// File: rtl/fetch_redir_arb.sv
// Redirect arbiter: picks exc > eret > br, word-aligns the target and
// parks an accepted redirect until the ROM completes the current fetch.
module fetch_redir_arb
    import fetch_ctrl_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_fetch,
    input  logic            i_rom_ready,
    input  logic            i_br_req,
    input  logic [PC_W-1:0] i_br_addr,
    input  logic            i_exc_req,
    input  logic            i_eret_req,
    input  logic [PC_W-1:0] i_epc,
    output logic            o_flush,
    output logic            o_redir,
    output logic            o_exc_acc,
    output logic [PC_W-1:0] o_target
);

    logic            r_pend_vld;
    redir_cls_e      r_pend_cls;
    logic [PC_W-1:0] r_pend_tgt;

    redir_cls_e      w_new_cls;
    logic [PC_W-1:0] w_new_raw;
    logic [PC_W-1:0] w_new_tgt;
    logic            w_acc;

    always_comb begin
        w_new_cls = RD_NONE;
        w_new_raw = '0;
        if (!i_fetch) begin
            w_new_cls = RD_NONE;
        end else if (i_exc_req) begin
            w_new_cls = RD_EXC;
            w_new_raw = EXC_VECTOR;
        end else if (i_eret_req) begin
            w_new_cls = RD_ERET;
            w_new_raw = i_epc;
        end else if (i_br_req) begin
            w_new_cls = RD_BR;
            w_new_raw = i_br_addr;
        end
    end

    assign w_new_tgt = w_new_raw & ~PC_W'(3);

    // A lower-class request cannot displace a parked higher-class one.
    assign w_acc = (w_new_cls != RD_NONE) &&
                   (!r_pend_vld || (w_new_cls >= r_pend_cls));

    assign o_flush   = w_acc;
    assign o_exc_acc = w_acc && (w_new_cls == RD_EXC);
    assign o_redir   = i_fetch && i_rom_ready && (w_acc || r_pend_vld);
    assign o_target  = w_acc ? w_new_tgt : r_pend_tgt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_vld <= 1'b0;
            r_pend_cls <= RD_NONE;
            r_pend_tgt <= '0;
        end else if (i_fetch && i_rom_ready) begin
            r_pend_vld <= 1'b0;
            r_pend_cls <= RD_NONE;
        end else if (w_acc) begin
            r_pend_vld <= 1'b1;
            r_pend_cls <= w_new_cls;
            r_pend_tgt <= w_new_tgt;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns pc, epc and the ROM chip enable,
// and steers the IF/ID register through if_valid and flush.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] PC_START   = PC_W'(PC_START_DEF),
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    fc_state_e       r_state;
    fc_state_e       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_epc;

    logic            w_fetch;
    logic            w_rom_ce;
    logic            w_if_valid;
    logic            w_flush;
    logic            w_redir;
    logic            w_exc_acc;
    logic [PC_W-1:0] w_target;

    assign w_fetch = (r_state == FC_S_FETCH);

    fetch_redir_arb #(
        .PC_W       (PC_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_fetch     (w_fetch),
        .i_rom_ready (bus.rom_ready),
        .i_br_req    (bus.br_req),
        .i_br_addr   (bus.br_addr),
        .i_exc_req   (bus.exc_req),
        .i_eret_req  (bus.eret_req),
        .i_epc       (r_epc),
        .o_flush     (w_flush),
        .o_redir     (w_redir),
        .o_exc_acc   (w_exc_acc),
        .o_target    (w_target)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FC_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rom_ce    = DISABLE;
        w_if_valid  = DISABLE;
        case (r_state)
            FC_S_IDLE: begin
                w_state_nxt = FC_S_FETCH;
            end
            FC_S_FETCH: begin
                w_rom_ce   = ENABLE;
                w_if_valid = bus.rom_ready && !w_redir && !bus.stall_req;
            end
            default: begin
                w_state_nxt = FC_S_IDLE;
            end
        endcase
    end

    // Redirects win over stall; a stalled completion refetches the same pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= PC_START;
        end else if (w_fetch && bus.rom_ready) begin
            if (w_redir) begin
                r_pc <= w_target;
            end else if (!bus.stall_req) begin
                r_pc <= r_pc + PC_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc <= '0;
        end else if (w_exc_acc) begin
            r_epc <= bus.exc_pc;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.epc      = r_epc;
    assign bus.romCe    = w_rom_ce;
    assign bus.if_valid = w_if_valid;
    assign bus.flush    = w_flush;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, redirects, stalls,
// wait-state priority, wrap-around and asynchronous reset.
module tb_fetch_ctrl;

    logic clk;
    logic rst;
    logic rst2;
    int   checks;
    int   failures;

    fetch_ctrl_if #(.PC_W(32)) bus ();
    fetch_ctrl_if #(.PC_W(32)) bus2 ();

    fetch_ctrl #(
        .PC_W       (32),
        .PC_START   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0020)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_ctrl #(
        .PC_W       (32),
        .PC_START   (32'hFFFF_FFFC),
        .EXC_VECTOR (32'h0000_0020)
    ) dut_wrap (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        rst2 = 1'b0;
        bus.rom_ready = 1'b1;
        bus.stall_req = 1'b0;
        bus.br_req    = 1'b0;
        bus.br_addr   = '0;
        bus.exc_req   = 1'b0;
        bus.exc_pc    = '0;
        bus.eret_req  = 1'b0;
        bus2.rom_ready = 1'b1;
        bus2.stall_req = 1'b0;
        bus2.br_req    = 1'b0;
        bus2.br_addr   = '0;
        bus2.exc_req   = 1'b0;
        bus2.exc_pc    = '0;
        bus2.eret_req  = 1'b0;
        #3;
        checks++;
        if (bus.pc !== 32'h0 || bus.romCe !== 1'b0 || bus.epc !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs pc=%h romCe=%b epc=%h want 0/0/0",
                     bus.pc, bus.romCe, bus.epc);
        end
        checks++;
        if (bus.if_valid !== 1'b0 || bus.flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_comb if_valid=%b flush=%b want 0/0",
                     bus.if_valid, bus.flush);
        end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] exp_pc;
        step();
        rst = 1'b1;
        bus.br_req = 1'b1;
        bus.br_addr = 32'h0000_0200;
        #1;
        checks++;
        if (bus.romCe !== 1'b0 || bus.if_valid !== 1'b0 || bus.flush !== 1'b0) begin
            failures++;
            $display("FAIL idle_cycle romCe=%b if_valid=%b flush=%b want 0/0/0",
                     bus.romCe, bus.if_valid, bus.flush);
        end
        step();
        bus.br_req = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.pc !== exp_pc || bus.romCe !== 1'b1 || bus.if_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch[%0d] pc=%h romCe=%b if_valid=%b want pc=%h 1/1",
                         i, bus.pc, bus.romCe, bus.if_valid, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            if (i < 2) step();
        end
    endtask

    task automatic test_branch();
        bus.br_req  = 1'b1;
        bus.br_addr = 32'h0000_0103;
        #1;
        checks++;
        if (bus.flush !== 1'b1 || bus.if_valid !== 1'b0 || bus.pc !== 32'h8) begin
            failures++;
            $display("FAIL br_accept flush=%b if_valid=%b pc=%h want 1/0/00000008",
                     bus.flush, bus.if_valid, bus.pc);
        end
        step();
        bus.br_req = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 32'h0000_0100 || bus.flush !== 1'b0 || bus.if_valid !== 1'b1) begin
            failures++;
            $display("FAIL br_target pc=%h flush=%b if_valid=%b want 00000100/0/1",
                     bus.pc, bus.flush, bus.if_valid);
        end
    endtask

    task automatic test_waitstate_priority();
        int flushes;
        flushes = 0;
        step();
        bus.rom_ready = 1'b0;
        bus.br_req    = 1'b1;
        bus.br_addr   = 32'h0000_0040;
        #1;
        if (bus.flush === 1'b1) flushes++;
        checks++;
        if (bus.if_valid !== 1'b0 || bus.pc !== 32'h104) begin
            failures++;
            $display("FAIL wait_hold if_valid=%b pc=%h want 0/00000104",
                     bus.if_valid, bus.pc);
        end
        step();
        bus.br_req  = 1'b0;
        bus.exc_req = 1'b1;
        bus.exc_pc  = 32'h0000_0010;
        #1;
        if (bus.flush === 1'b1) flushes++;
        step();
        bus.exc_req = 1'b0;
        #1;
        if (bus.flush === 1'b1) flushes++;
        checks++;
        if (bus.epc !== 32'h10 || bus.pc !== 32'h104) begin
            failures++;
            $display("FAIL wait_epc epc=%h pc=%h want 00000010/00000104",
                     bus.epc, bus.pc);
        end
        step();
        bus.rom_ready = 1'b1;
        #1;
        if (bus.flush === 1'b1) flushes++;
        checks++;
        if (bus.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_apply if_valid=%b want 0", bus.if_valid);
        end
        step();
        #1;
        checks++;
        if (bus.pc !== 32'h0000_0020 || bus.epc !== 32'h10) begin
            failures++;
            $display("FAIL exc_target pc=%h epc=%h want 00000020/00000010",
                     bus.pc, bus.epc);
        end
        checks++;
        if (flushes != 2) begin
            failures++;
            $display("FAIL flush_count got=%0d want=2", flushes);
        end
    endtask

    task automatic test_stall_eret();
        step();
        bus.stall_req = 1'b1;
        #1;
        checks++;
        if (bus.pc !== 32'h24 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_0 pc=%h if_valid=%b want 00000024/0",
                     bus.pc, bus.if_valid);
        end
        step();
        #1;
        checks++;
        if (bus.pc !== 32'h24 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_1 pc=%h if_valid=%b want 00000024/0",
                     bus.pc, bus.if_valid);
        end
        step();
        bus.eret_req = 1'b1;
        #1;
        checks++;
        if (bus.pc !== 32'h24 || bus.flush !== 1'b1 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL eret_accept pc=%h flush=%b if_valid=%b want 00000024/1/0",
                     bus.pc, bus.flush, bus.if_valid);
        end
        step();
        bus.eret_req  = 1'b0;
        bus.stall_req = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 32'h10 || bus.epc !== 32'h10) begin
            failures++;
            $display("FAIL eret_target pc=%h epc=%h want 00000010/00000010",
                     bus.pc, bus.epc);
        end
    endtask

    task automatic test_wrap();
        checks++;
        if (bus2.pc !== 32'hFFFF_FFFC || bus2.romCe !== 1'b0) begin
            failures++;
            $display("FAIL wrap_reset pc=%h romCe=%b want fffffffc/0",
                     bus2.pc, bus2.romCe);
        end
        step();
        rst2 = 1'b1;
        step();
        #1;
        checks++;
        if (bus2.pc !== 32'hFFFF_FFFC || bus2.if_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_first pc=%h if_valid=%b want fffffffc/1",
                     bus2.pc, bus2.if_valid);
        end
        step();
        #1;
        checks++;
        if (bus2.pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_zero pc=%h want 00000000", bus2.pc);
        end
        step();
        #1;
        checks++;
        if (bus2.pc !== 32'h4) begin
            failures++;
            $display("FAIL wrap_next pc=%h want 00000004", bus2.pc);
        end
    endtask

    task automatic test_async_reset();
        step();
        bus.rom_ready = 1'b0;
        bus.br_req    = 1'b1;
        bus.br_addr   = 32'h0000_0080;
        step();
        bus.br_req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 32'h0 || bus.romCe !== 1'b0 || bus.epc !== 32'h0) begin
            failures++;
            $display("FAIL async_rst pc=%h romCe=%b epc=%h want 0/0/0",
                     bus.pc, bus.romCe, bus.epc);
        end
        bus.rom_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        #1;
        checks++;
        if (bus.pc !== 32'h0 || bus.if_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_refetch pc=%h if_valid=%b want 00000000/1",
                     bus.pc, bus.if_valid);
        end
        step();
        #1;
        checks++;
        if (bus.pc !== 32'h4) begin
            failures++;
            $display("FAIL rst_no_redir pc=%h want 00000004", bus.pc);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_seq_fetch();
        test_branch();
        test_waitstate_priority();
        test_stall_eret();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
